// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with 2**ADDR_WIDTH usable entries, occupancy count,
// full/empty/almost flags and sticky overflow/underflow error flags.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads
// are registered (DataOut/DOR update on the edge that accepts a pop).
// Legal configurations satisfy 0 <= AE_THRESH < AF_THRESH <= 2**ADDR_WIDTH.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  W_EN,
  input  logic                  R_EN,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  ErrClr,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DIR,
  output logic                  DOR,
  output logic                  Full,
  output logic                  Empty,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  localparam logic [CntW-1:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CntW-1:0] AfThr    = AF_THRESH[CntW-1:0];
  localparam logic [CntW-1:0] AeThr    = AE_THRESH[CntW-1:0];

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic full, empty;
  logic push_acc, pop_acc;
  logic ovf_set, unf_set;

  // Status flags decode the count register only; full/empty never look at pointers.
  always_comb begin
    full        = (count_q == DepthCnt);
    empty       = (count_q == '0);
    Full        = full;
    Empty       = empty;
    DIR         = ~full;
    AlmostFull  = (count_q >= AfThr);
    AlmostEmpty = (count_q <= AeThr);
    Count       = count_q;
    Overflow    = ovf_q;
    Underflow   = unf_q;
  end

  // Handshake decode; a push into a full FIFO is fine when a pop frees a slot on the same edge.
  always_comb begin
    pop_acc  = EN & R_EN & ~empty;
    push_acc = EN & W_EN & (~full | pop_acc);
    ovf_set  = EN & W_EN & full & ~pop_acc;
    unf_set  = EN & R_EN & empty;
  end

  // Next-state for pointers, occupancy and error flags; everything holds while EN is low.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (EN) begin
      if (push_acc) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
      if (pop_acc)  r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
      if (push_acc && !pop_acc) begin
        count_d = count_q + CntW'(1);
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - CntW'(1);
      end
      // Set has priority over a coincident clear.
      ovf_d = ovf_set | (ovf_q & ~ErrClr);
      unf_d = unf_set | (unf_q & ~ErrClr);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst && push_acc) begin
      mem_q[w_ptr_q] <= DataIn;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; it is meaningful only while DOR is high.
  always_comb begin
    DataOut = mem_q[r_ptr_q];
    DOR     = ~empty;
  end
`else
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dor_q, dor_d;

  // Registered read: capture the head on an accepted pop, DOR pulses for one cycle.
  always_comb begin
    data_d = data_q;
    dor_d  = 1'b0;
    if (pop_acc) begin
      data_d = mem_q[r_ptr_q];
      dor_d  = 1'b1;
    end
  end

  // Read data registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      dor_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dor_q  <= dor_d;
    end
  end

  // Drive read outputs from the registers.
  always_comb begin
    DataOut = data_q;
    DOR     = dor_q;
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed scenarios followed by random traffic,
// all compared each cycle against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic       clk;
  logic       rst;
  logic       EN, W_EN, R_EN, ErrClr;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       DIR, DOR, Full, Empty, AlmostFull, AlmostEmpty, Overflow, Underflow;
  logic [4:0] Count;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ovf, m_unf, m_dor;
  logic [7:0] m_dout;

  fifo_sync_param #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .EN         (EN),
    .W_EN       (W_EN),
    .R_EN       (R_EN),
    .DataIn     (DataIn),
    .ErrClr     (ErrClr),
    .DataOut    (DataOut),
    .DIR        (DIR),
    .DOR        (DOR),
    .Full       (Full),
    .Empty      (Empty),
    .AlmostFull (AlmostFull),
    .AlmostEmpty(AlmostEmpty),
    .Count      (Count),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the FIFO's contract.
  task automatic model_step(input bit rstn, en, we, re, ec, input logic [7:0] din);
    bit pop, push, oset, uset;
    int n;
    if (!rstn) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_dout = 8'h00; m_dor = 0;
      return;
    end
    if (!en) begin
      m_dor = 0;
      return;
    end
    n    = mq.size();
    pop  = re && (n > 0);
    push = we && ((n < D) || pop);
    oset = we && (n == D) && !pop;
    uset = re && (n == 0);
    m_dor = pop;
    if (pop)  m_dout = mq.pop_front();
    if (push) mq.push_back(din);
    m_ovf = oset || (m_ovf && !ec);
    m_unf = uset || (m_unf && !ec);
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    check_eq("count",   32'(Count),       32'(n));
    check_eq("empty",   32'(Empty),       32'(n == 0));
    check_eq("full",    32'(Full),        32'(n == D));
    check_eq("dir",     32'(DIR),         32'(n != D));
    check_eq("afull",   32'(AlmostFull),  32'(n >= AF));
    check_eq("aempty",  32'(AlmostEmpty), 32'(n <= AE));
    check_eq("ovf",     32'(Overflow),    32'(m_ovf));
    check_eq("unf",     32'(Underflow),   32'(m_unf));
`ifdef FIFO_FWFT_EN
    check_eq("dor",     32'(DOR),         32'(n > 0));
    if (n > 0) check_eq("dout", 32'(DataOut), 32'(mq[0]));
`else
    check_eq("dor",     32'(DOR),         32'(m_dor));
    check_eq("dout",    32'(DataOut),     32'(m_dout));
`endif
  endtask

  // Apply one cycle of inputs, update the model at the edge, check #1 after it.
  task automatic step(input bit rstn, en, we, re, ec, input logic [7:0] din);
    rst = rstn; EN = en; W_EN = we; R_EN = re; ErrClr = ec; DataIn = din;
    @(posedge clk);
    model_step(rstn, en, we, re, ec, din);
    #1;
    check_all();
  endtask

  task automatic push(input logic [7:0] d); step(1, 1, 1, 0, 0, d); endtask
  task automatic pop();                     step(1, 1, 0, 1, 0, 8'h00); endtask
  task automatic idle();                    step(1, 1, 0, 0, 0, 8'h00); endtask
  task automatic clr();                     step(1, 1, 0, 0, 1, 8'h00); endtask

  initial begin
    rst = 0; EN = 0; W_EN = 0; R_EN = 0; ErrClr = 0; DataIn = 0;
    m_ovf = 0; m_unf = 0; m_dor = 0; m_dout = 0;

    // Reset
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 0, 8'h5A);
    check_eq("rst_count", 32'(Count), 32'd0);
    check_eq("rst_dir",   32'(DIR),   32'd1);

    // 1: three pushes, three pops
    push(8'h11); push(8'h22); push(8'h33);
    check_eq("t1_count", 32'(Count), 32'd3);
    check_eq("t1_aempty", 32'(AlmostEmpty), 32'd0);
    pop();
`ifndef FIFO_FWFT_EN
    check_eq("t1_first", 32'(DataOut), 32'h11);
`endif
    pop(); pop(); idle();
    check_eq("t1_empty", 32'(Empty), 32'd1);

    // 2: fill, then overflow attempt
    for (int i = 0; i < D; i++) push(8'(i));
    check_eq("t2_full", 32'(Full), 32'd1);
    push(8'hAA);
    check_eq("t2_ovf",   32'(Overflow), 32'd1);
    check_eq("t2_count", 32'(Count),    32'd16);
    clr();
    check_eq("t2_clr", 32'(Overflow), 32'd0);

    // 3: push+pop while full, then drain
    step(1, 1, 1, 1, 0, 8'h55);
    check_eq("t3_count", 32'(Count),    32'd16);
    check_eq("t3_ovf",   32'(Overflow), 32'd0);
    for (int i = 0; i < D; i++) pop();
    idle();

    // 4: underflow, clear, push+pop on empty
    pop();
    check_eq("t4_unf", 32'(Underflow), 32'd1);
    clr();
    step(1, 1, 1, 1, 0, 8'h7E);
    check_eq("t4_count", 32'(Count),     32'd1);
    check_eq("t4_unf2",  32'(Underflow), 32'd1);
    pop(); clr();

    // 5: 40 push/pop pairs across pointer wrap, then reset with Count=5
    for (int i = 0; i < 40; i++) begin
      push(8'(8'h80 + i));
      pop();
    end
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    check_eq("t5_count5", 32'(Count), 32'd5);
    step(0, 1, 0, 0, 0, 8'h00);
    check_eq("t5_rst_count", 32'(Count),   32'd0);
    check_eq("t5_rst_dor",   32'(DOR),     32'd0);
`ifndef FIFO_FWFT_EN
    check_eq("t5_rst_dout",  32'(DataOut), 32'd0);
`endif
    push(8'h3C); pop();
`ifndef FIFO_FWFT_EN
    check_eq("t5_first_after_rst", 32'(DataOut), 32'h3C);
`endif

`ifdef FIFO_FWFT_EN
    // 6: fall-through visibility
    push(8'h9C);
    check_eq("t6_dor",  32'(DOR),     32'd1);
    check_eq("t6_dout", 32'(DataOut), 32'h9C);
    pop();
    check_eq("t6_dor0", 32'(DOR),     32'd0);
`endif

    // Random traffic with write-heavy and read-heavy phases
    for (int ph = 0; ph < 12; ph++) begin
      int wb, rb;
      wb = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
      rb = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      for (int c = 0; c < 250; c++) begin
        bit r_n, e, w, r, ec;
        r_n = ($urandom_range(0, 299) != 0);
        e   = ($urandom_range(0, 7) != 0);
        w   = ($urandom_range(0, 99) < wb);
        r   = ($urandom_range(0, 99) < rb);
        ec  = e && ($urandom_range(0, 15) == 0);
        step(r_n, e, w, r, ec, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Synchronous single-clock FIFO. It is the parametrised successor to the team's register FIFO, with independent data width and depth.
- All 2**ADDR_WIDTH entries are usable.
- Adds full/empty/almost flags, an occupancy count, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages as a general buffering element; reads are registered by default, with an optional first-word-fall-through mode.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries (16).
- AF_THRESH, 14, AlmostFull asserts when Count >= AF_THRESH.
- AE_THRESH, 2, AlmostEmpty asserts when Count <= AE_THRESH.
- Legal only if 0 <= AE_THRESH < AF_THRESH <= DEPTH.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-low reset.
- EN  input  1  global enable; when 0 no push/pop is accepted and no error flag is set.
- W_EN  input  1  push request.
- R_EN  input  1  pop request.
- DataIn  input  DATA_WIDTH  write data.
- ErrClr  input  1  synchronous clear of Overflow/Underflow.
- DataOut  output  DATA_WIDTH  read data.
- DIR  output  1  data-in ready, equals !Full.
- DOR  output  1  data-out ready (see Behaviour).
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- AlmostFull  output  1  Count >= AF_THRESH.
- AlmostEmpty  output  1  Count <= AE_THRESH.
- Count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- Overflow  output  1  sticky: push attempted while full.
- Underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst==0 at clk edge):
  - Pointers = 0, Count = 0, DataOut = 0, DOR = 0.
  - Overflow = 0, Underflow = 0.
  - Resulting flags: DIR = 1, Full = 0, Empty = 1, AlmostEmpty = 1, AlmostFull = 0.
  - Memory contents are not cleared. Reset mid-traffic discards all stored words; the first push after reset is the first word read.
- Push accepted: EN & W_EN & (!Full | pop_accepted). mem[w_ptr] <= DataIn; w_ptr increments modulo DEPTH.
- Pop accepted: EN & R_EN & !Empty. r_ptr increments modulo DEPTH.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both are accepted; Count stays DEPTH; no Overflow.
  - When empty: the push is accepted, the pop is rejected, and Underflow is set. Count becomes 1.
- Overflow is set on EN & W_EN & Full & !pop_accepted. Underflow is set on EN & R_EN & Empty.
- Both error flags hold until ErrClr==1 or reset. If set and clear coincide, set wins.
- Flags (DIR, Full, Empty, AlmostFull, AlmostEmpty) are combinational decodes of the Count register, so they update in the cycle after the causing edge.
- Pointer wrap: DEPTH-1 -> 0, with no special handling. Full/empty are decided by Count, not by pointer equality.
- Default read timing (registered):
  - On an accepted pop, DataOut <= mem[r_ptr] at the same edge; data is visible 1 cycle after R_EN is sampled.
  - DOR <= 1 for exactly the cycle following each accepted pop, else 0.
  - DataOut holds its last value when no pop occurs.
- EN==0: pointers, Count, DataOut and error flags hold; DOR <= 0.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - DataOut = mem[r_ptr] combinationally; DOR = !Empty.
  - The head word is visible with no R_EN. An accepted pop advances to the next word in the same cycle.
  - A word pushed into an empty FIFO appears on DataOut one cycle after its push edge.
  - DataOut is don't-care while DOR==0.
  - Reset value of DOR is 0 (FIFO empty); DataOut is not a register in this mode.
- Undefined: registered read timing as above.
- All other behaviour is identical in both modes.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 -> Count=3, Empty=0, AlmostEmpty=0. Three pops -> DataOut 0x11,0x22,0x33 in order, DOR pulses once per pop, final Count=0, Empty=1.
2. Push 16 words 0x00..0x0F -> AlmostFull asserts after the 14th, Full=1/DIR=0 after the 16th. A 17th push (0xAA) -> Overflow=1, Count=16, 0xAA never read back.
3. With the FIFO full, assert W_EN (0x55) and R_EN in one cycle -> Count stays 16, Overflow stays 0. Draining yields 0x01..0x0F then 0x55.
4. Empty FIFO: pop -> Underflow=1, DOR=0, Count=0. ErrClr pulse -> Underflow=0. Simultaneous push 0x7E and pop on empty -> Count=1, Underflow=1.
5. Loop 40 push/pop pairs with incrementing data (forces pointer wrap twice) -> data read back in order, Count oscillates 0/1 with no errors. Then assert rst=0 mid-stream with Count=5 -> next cycle Count=0, Empty=1, DOR=0, DataOut=0.
6. With FIFO_FWFT_EN defined, push 0x9C into an empty FIFO -> the next cycle DOR=1 and DataOut=0x9C with no R_EN. Pop -> DOR=0 the next cycle.
